key_event_queue: RTL and testbench

- Single-clock, parametrised queue for PS/2 key events from keyboard_press_driver.
- Buffers {makeBreak, outCode} events in a first-word-fall-through FIFO, so game logic can consume them at its own pace.
- Optionally drops typematic repeats, using a per-key held bitmap.
- Full-queue policy is selectable: drop newest or overwrite oldest.
- Sticky overflow flag and a saturating drop counter.

---
 rtl/key_event_pkg.sv | 30 +++
 rtl/key_event_queue_if.sv | 37 +++
 rtl/key_event_queue_fifo_core.sv | 67 ++++++
 rtl/key_event_queue.sv | 87 ++++++++
 tb/tb_key_event_queue.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/key_event_pkg.sv
// +-------------------------------------------------------------------+
// | key_event_pkg : shared key-event types and Tetris keycodes        |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package key_event_pkg;

    typedef struct packed {
        logic       makeBreak;
        logic [7:0] code;
    } key_event_t;

    localparam logic MAKE  = 1'b1;
    localparam logic BREAK = 1'b0;

    // PS/2 scan-code set 2 codes of the game controls
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_event_queue_if.sv
// +-------------------------------------------------------------------+
// | key_event_queue_if : event-in / event-out bundle of the key queue |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

interface key_event_queue_if #(
    parameter int CODE_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 in_valid;
    logic                 in_makeBreak;
    logic [CODE_W-1:0]    in_code;
    logic                 rd_ready;
    logic                 clear_overflow;
    logic                 out_valid;
    logic                 out_makeBreak;
    logic [CODE_W-1:0]    out_code;
    logic [CNT_W-1:0]     count;
    logic [2**CODE_W-1:0] held;
    logic                 overflow;
    logic [7:0]           drop_cnt;

    modport master (
        output in_valid, in_makeBreak, in_code, rd_ready, clear_overflow,
        input  out_valid, out_makeBreak, out_code, count, held, overflow, drop_cnt
    );

    modport slave (
        input  in_valid, in_makeBreak, in_code, rd_ready, clear_overflow,
        output out_valid, out_makeBreak, out_code, count, held, overflow, drop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/key_event_queue_fifo_core.sv
// +-------------------------------------------------------------------+
// | key_event_fifo_core : single-clock FWFT FIFO with overwrite mode  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module key_event_fifo_core #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         push_i,
    input  wire logic                         pop_i,
    input  wire logic                         overwrite_i,
    input  wire logic [WIDTH-1:0]             din_i,
    output logic      [WIDTH-1:0]             dout_o,
    output logic      [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                              full_o,
    output logic                              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_write, w_adv_rd;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Overwrite at full retires the oldest entry, so the read side advances too
    assign w_write  = push_i && (!full_o || pop_i || overwrite_i);
    assign w_adv_rd = (pop_i && !empty_o) || (push_i && full_o && !pop_i && overwrite_i);

    always_comb begin
        count_d = count_q;
        case ({w_write, w_adv_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_write)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_adv_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/key_event_queue.sv
// +-------------------------------------------------------------------+
// | key_event_queue : filtered PS/2 key-event queue with drop stats   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module key_event_queue
    import key_event_pkg::*;
#(
    parameter int CODE_W      = 8,
    parameter int DEPTH       = 16,
    parameter int DROP_REPEAT = 1,
    parameter int OVERWRITE   = 0
) (
    input  wire logic        CLOCK_50,
    input  wire logic        reset,
    key_event_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EW    = CODE_W + 1;

    logic [2**CODE_W-1:0] held_q, held_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic                 w_accept, w_pop, w_drop, w_full, w_empty;
    logic [EW-1:0]        w_head;
    logic [CNT_W-1:0]     w_count;

    assign w_pop    = !w_empty && bus.rd_ready;
    assign w_accept = bus.in_valid &&
                      !((DROP_REPEAT != 0) && bus.in_makeBreak && held_q[bus.in_code]);
    // A full-queue push is lost (or overwrites) only when no pop frees a slot
    assign w_drop   = w_accept && w_full && !w_pop;

    key_event_fifo_core #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CLOCK_50),
        .rst         (reset),
        .push_i      (w_accept),
        .pop_i       (w_pop),
        .overwrite_i (OVERWRITE != 0),
        .din_i       ({bus.in_makeBreak, bus.in_code}),
        .dout_o      (w_head),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    always_comb begin
        held_d     = held_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.in_valid) held_d[bus.in_code] = bus.in_makeBreak;
        if (bus.clear_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
        if (w_drop) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc8(drop_cnt_d);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            held_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            held_q     <= held_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.out_valid                    = !w_empty;
    assign {bus.out_makeBreak, bus.out_code} = w_head;
    assign bus.count                        = w_count;
    assign bus.held                         = held_q;
    assign bus.overflow                     = overflow_q;
    assign bus.drop_cnt                     = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_key_event_queue.sv
// +-------------------------------------------------------------------+
// | tb_key_event_queue : two queue configurations against a list model|
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_key_event_queue;
    import key_event_pkg::*;

    localparam int MD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0, s_mb = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
    logic [7:0] s_code = 8'h00;
    bit         started = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // ifa/ua: repeat filter on, drop newest.  ifb/ub: filter off, overwrite oldest.
    key_event_queue_if #(.CODE_W(8), .DEPTH(MD)) ifa ();
    key_event_queue_if #(.CODE_W(8), .DEPTH(MD)) ifb ();

    assign ifa.in_valid = s_valid;  assign ifb.in_valid = s_valid;
    assign ifa.in_makeBreak = s_mb; assign ifb.in_makeBreak = s_mb;
    assign ifa.in_code = s_code;    assign ifb.in_code = s_code;
    assign ifa.rd_ready = s_rd;     assign ifb.rd_ready = s_rd;
    assign ifa.clear_overflow = s_clr; assign ifb.clear_overflow = s_clr;

    key_event_queue #(.CODE_W(8), .DEPTH(MD), .DROP_REPEAT(1), .OVERWRITE(0))
        ua (.CLOCK_50(clk), .reset(rst), .bus(ifa));
    key_event_queue #(.CODE_W(8), .DEPTH(MD), .DROP_REPEAT(0), .OVERWRITE(1))
        ub (.CLOCK_50(clk), .reset(rst), .bus(ifb));

    // ---------------- behavioural model: ordered list per instance ----------
    logic [8:0]   mq    [2][MD];
    int           msz   [2];
    logic [255:0] mheld [2];
    logic         mov   [2];
    logic [7:0]   mdc   [2];

    function automatic bit cfg_dr(input int k); return (k == 0); endfunction
    function automatic bit cfg_ow(input int k); return (k == 1); endfunction

    task automatic pop_front(input int k);
        for (int i = 0; i < MD - 1; i++) mq[k][i] = mq[k][i+1];
        msz[k] = msz[k] - 1;
    endtask

    task automatic push_back(input int k, input logic [8:0] e);
        mq[k][msz[k]] = e;
        msz[k] = msz[k] + 1;
    endtask

    task automatic model_step(input int k);
        int  pre;
        bit  pop, acc, drop;
        pre  = msz[k];
        pop  = (pre > 0) && s_rd;
        acc  = s_valid && !(cfg_dr(k) && s_mb && mheld[k][s_code]);
        drop = 1'b0;
        if (pop) pop_front(k);
        if (acc) begin
            if (pre < MD || pop) push_back(k, {s_mb, s_code});
            else begin
                drop = 1'b1;
                if (cfg_ow(k)) begin
                    pop_front(k);
                    push_back(k, {s_mb, s_code});
                end
            end
        end
        if (s_clr) begin mov[k] = 1'b0; mdc[k] = 8'd0; end
        if (drop) begin
            mov[k] = 1'b1;
            if (mdc[k] != 8'hFF) mdc[k] = mdc[k] + 8'd1;
        end
        if (s_valid) mheld[k][s_code] = s_mb;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                msz[k] = 0; mheld[k] = '0; mov[k] = 1'b0; mdc[k] = 8'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // ---------------- checking ----------------------------------------------
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_inst(input int k, input logic ov, input logic mb, input logic [7:0] cd,
                            input logic [2:0] cnt, input logic [255:0] hd, input logic of,
                            input logic [7:0] dc);
        logic [8:0] hexp;
        hexp = (msz[k] > 0) ? mq[k][0] : 9'h000;
        chk($sformatf("u%0d.out_valid", k), ov, msz[k] > 0);
        chk($sformatf("u%0d.head", k), {mb, cd}, hexp);
        chk($sformatf("u%0d.count", k), cnt, msz[k]);
        chk($sformatf("u%0d.held", k), hd, mheld[k]);
        chk($sformatf("u%0d.overflow", k), of, mov[k]);
        chk($sformatf("u%0d.drop_cnt", k), dc, mdc[k]);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp_inst(0, ifa.out_valid, ifa.out_makeBreak, ifa.out_code, ifa.count,
                     ifa.held, ifa.overflow, ifa.drop_cnt);
            cmp_inst(1, ifb.out_valid, ifb.out_makeBreak, ifb.out_code, ifb.count,
                     ifb.held, ifb.overflow, ifb.drop_cnt);
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic cyc(input bit v, input bit mb, input logic [7:0] c, input bit rd, input bit clr);
        s_valid = v; s_mb = mb; s_code = c; s_rd = rd; s_clr = clr;
        @(posedge clk);
        #2;
        s_valid = 1'b0; s_mb = 1'b0; s_code = 8'h00; s_rd = 1'b0; s_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] exp6 [4];
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        started = 1'b1;
        chk("reset A.out_valid", ifa.out_valid, 1'b0);
        chk("reset A.count", ifa.count, 3'd0);
        chk("reset B.out_code", ifb.out_code, 8'h00);

        // pass-through
        cyc(1, MAKE, 8'h1D, 0, 0);
        chk("pt A.out_valid", ifa.out_valid, 1'b1);
        chk("pt A.held1D set", ifa.held[8'h1D], 1'b1);
        cyc(1, BREAK, 8'h1D, 0, 0);
        chk("pt A.count", ifa.count, 3'd2);
        chk("pt A.held1D clr", ifa.held[8'h1D], 1'b0);
        chk("pt A.head1", {ifa.out_makeBreak, ifa.out_code}, 9'h11D);
        cyc(0, 0, 8'h00, 1, 0);
        chk("pt A.head2", {ifa.out_makeBreak, ifa.out_code}, 9'h01D);
        cyc(0, 0, 8'h00, 1, 0);
        chk("pt A.empty", ifa.out_valid, 1'b0);

        // repeat filter
        repeat (3) cyc(1, MAKE, KEY_UP, 0, 0);
        cyc(1, BREAK, KEY_UP, 0, 0);
        chk("rep A.count", ifa.count, 3'd2);
        chk("rep B.count", ifb.count, 3'd4);
        chk("rep A.drop_cnt", ifa.drop_cnt, 8'd0);
        chk("rep B.drop_cnt", ifb.drop_cnt, 8'd0);
        chk("rep A.head", {ifa.out_makeBreak, ifa.out_code}, 9'h175);
        repeat (4) cyc(0, 0, 8'h00, 1, 0);
        chk("rep B.drained", ifb.count, 3'd0);

        // full: drop (A) vs overwrite (B)
        for (int c = 1; c <= 6; c++) cyc(1, MAKE, 8'(c), 0, 0);
        chk("full A.count", ifa.count, 3'd4);
        chk("full A.overflow", ifa.overflow, 1'b1);
        chk("full A.drop_cnt", ifa.drop_cnt, 8'd2);
        chk("full B.count", ifb.count, 3'd4);
        chk("full B.drop_cnt", ifb.drop_cnt, 8'd2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full A.pop%0d", i), ifa.out_code, 8'(i + 1));
            chk($sformatf("full B.pop%0d", i), ifb.out_code, 8'(i + 3));
            cyc(0, 0, 8'h00, 1, 0);
        end
        cyc(0, 0, 8'h00, 0, 1);
        chk("clr A.overflow", ifa.overflow, 1'b0);
        chk("clr A.drop_cnt", ifa.drop_cnt, 8'd0);

        // simultaneous push and pop at full, across a pointer wrap
        for (int c = 0; c < 4; c++) cyc(1, MAKE, 8'(8'h10 + c), 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, MAKE, 8'(8'h20 + i), 1, 0);
            chk($sformatf("pp A.count%0d", i), ifa.count, 3'd4);
            chk($sformatf("pp A.overflow%0d", i), ifa.overflow, 1'b0);
            chk($sformatf("pp B.count%0d", i), ifb.count, 3'd4);
        end
        exp6[0] = 8'h13; exp6[1] = 8'h20; exp6[2] = 8'h21; exp6[3] = 8'h22;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp A.pop%0d", i), ifa.out_code, exp6[i]);
            chk($sformatf("pp B.pop%0d", i), ifb.out_code, exp6[i]);
            cyc(0, 0, 8'h00, 1, 0);
        end

        // clear in the same cycle as a full-drop: the set wins
        for (int c = 0; c < 4; c++) cyc(1, MAKE, 8'(8'h30 + c), 0, 0);
        cyc(1, MAKE, 8'h34, 0, 1);
        chk("clrset A.overflow", ifa.overflow, 1'b1);
        chk("clrset A.drop_cnt", ifa.drop_cnt, 8'd1);
        chk("clrset B.overflow", ifb.overflow, 1'b1);
        chk("clrset B.drop_cnt", ifb.drop_cnt, 8'd1);
        chk("clrset B.head", ifb.out_code, 8'h31);

        // asynchronous reset mid-cycle
        repeat (4) cyc(0, 0, 8'h00, 1, 0);
        for (int c = 0; c < 3; c++) cyc(1, MAKE, 8'(8'h40 + c), 0, 0);
        chk("ar A.count pre", ifa.count, 3'd3);
        rst = 1'b1;
        #1;
        chk("ar A.count", ifa.count, 3'd0);
        chk("ar A.out_valid", ifa.out_valid, 1'b0);
        chk("ar A.held", ifa.held, 256'd0);
        chk("ar A.overflow", ifa.overflow, 1'b0);
        chk("ar B.drop_cnt", ifb.drop_cnt, 8'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cyc(1, MAKE, KEY_SPACE, 0, 0);
        chk("post A.head", {ifa.out_makeBreak, ifa.out_code}, 9'h129);
        repeat (2) cyc(0, 0, 8'h00, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
